// File: rtl/freq_meter_circuit.sv
// Gated frequency counter: counts rising edges of an asynchronous input over
// a fixed window of GATE_TICKS clk_in cycles, then publishes the count.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | stopped; waiting for enable
//   ST_GATE  | window open; counting synchronized rising edges
//   ST_LATCH | one dead cycle after a window; new result is on the outputs
module freq_meter_circuit #(
  parameter int GATE_TICKS  = 100000000,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   sig_in,
  input  logic                   enable,
  output logic [COUNT_WIDTH-1:0] freq_count,
  output logic                   valid,
  output logic                   overflow,
  output logic                   busy
);

  localparam int TIMER_WIDTH = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(GATE_TICKS - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_LATCH
  } state_t;

  state_t                 state;
  logic                   sync1;
  logic                   sync2;
  logic                   prev;
  logic                   sig_edge;
  logic [TIMER_WIDTH-1:0] timer;
  logic [COUNT_WIDTH-1:0] edge_cnt;
  logic [COUNT_WIDTH-1:0] cnt_next;
  logic                   sat;
  logic                   sat_next;

  // Two-flop synchronizer plus one history flop for rising-edge detection.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign sig_edge = sync2 & ~prev;

  // Saturating edge count; an edge arriving at full scale marks the window as saturated.
  always_comb begin
    cnt_next = edge_cnt;
    sat_next = sat;
    if (sig_edge) begin
      if (edge_cnt == COUNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        cnt_next = edge_cnt + COUNT_WIDTH'(1);
      end
    end
  end

  // Window sequencing. The timer runs down from GATE_TICKS-1 and the window
  // closes on terminal count; the result is registered on that same edge so
  // freq_count, overflow and valid are all visible during the LATCH cycle.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq_count <= '0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            timer    <= TIMER_LAST;
            edge_cnt <= '0;
            sat      <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_GATE;
          end
        end
        ST_GATE: begin
          if (!enable) begin
            // Abort: partial count is discarded, published result untouched.
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (timer == '0) begin
            freq_count <= cnt_next;
            overflow   <= sat_next;
            valid      <= 1'b1;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            timer      <= TIMER_LAST;
            state      <= ST_LATCH;
          end else begin
            edge_cnt <= cnt_next;
            sat      <= sat_next;
            timer    <= timer - TIMER_WIDTH'(1);
          end
        end
        ST_LATCH: begin
          // Edges seen in this cycle are intentionally dropped.
          edge_cnt <= '0;
          sat      <= 1'b0;
          timer    <= TIMER_LAST;
          busy     <= enable;
          state    <= enable ? ST_GATE : ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter_circuit.sv
// Bench for freq_meter_circuit with a 1000-cycle window and a 7-bit counter.
// Expected counts come from the recorded per-cycle sig_in samples and the
// window schedule implied by the enable/reset timing.
module tb_freq_meter_circuit;

  localparam int GT   = 1000;
  localparam int CW   = 7;
  localparam int CMAX = 127;
  localparam int CAD  = GT + 1;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          sig_in = 1'b0;
  logic          enable;
  logic [CW-1:0] freq_count;
  logic          valid;
  logic          overflow;
  logic          busy;

  int   checks = 0;
  int   errors = 0;

  // sig_in as sampled at each rising clk_in edge; index = edge number
  bit   v[$];

  // stimulus generator controls: 0 = constant lvl, 1 = square wave, 2 = random runs
  int   mode = 0;
  int   per  = 10;
  int   ph   = 0;
  int   rr   = 0;
  int   rmax = 9;
  logic lvl  = 1'b0;

  // window schedule reference: first GATE cycle index, and whether to check
  int   e      = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int   mode;
    int   per;
    logic lvl;
    int   exp_cnt;
    int   exp_ovf;
  } vec_t;

  vec_t tbl[8];

  freq_meter_circuit #(
    .GATE_TICKS (GT),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .sig_in    (sig_in),
    .enable    (enable),
    .freq_count(freq_count),
    .valid     (valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) v.push_back(sig_in);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // sig_in generator, updated just after each rising edge
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      case (mode)
        0: sig_in = lvl;
        1: begin
          sig_in = (ph >= per / 2);
          ph     = (ph + 1) % per;
        end
        default: begin
          if (rr <= 0) begin
            sig_in = ~sig_in;
            rr     = int'($urandom_range(rmax, 2));
          end
          rr--;
        end
      endcase
    end
  end

  // Reference: windows of GT gate cycles at e + j*CAD; the result appears in
  // the cycle e + j*CAD + GT. A gate cycle k counts a rise seen as samples
  // v[k-2]=0, v[k-1]=1 (two-flop synchronizer latency).
  initial begin
    int k, rel, raw, expc, expo;
    bit expv;
    forever begin
      @(negedge clk_in);
      if (mon_en) begin
        k   = v.size() - 1;
        rel = k - e;
        if (rel >= 0) begin
          expv = ((rel % CAD) == GT);
          chk("mon_busy", busy, 1);
          chk("mon_valid", valid, int'(expv));
          if (expv) begin
            raw = 0;
            for (int kk = k - GT; kk < k; kk++) begin
              if (v[kk-1] && !v[kk-2]) raw++;
            end
            expc = (raw > CMAX) ? CMAX : raw;
            expo = (raw > CMAX) ? 1 : 0;
            chk("mon_count", freq_count, expc);
            chk("mon_ovf", overflow, expo);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_run(input int m, input int p, input logic l);
    @(negedge clk_in);
    mode = m;
    per  = p;
    lvl  = l;
    ph   = 0;
    rr   = 0;
    repeat (6) @(posedge clk_in);
    #1;
    chk("idle_busy", busy, 0);
    enable = 1'b1;
    e      = v.size();
    mon_en = 1'b1;
  endtask

  task automatic stop_run();
    @(posedge clk_in);
    #1;
    enable = 1'b0;
    mon_en = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!valid && n < CAD + 100);
    chk({nm, "_valid_seen"}, valid, 1);
  endtask

  initial begin
    int nv;
    tbl[0] = '{1, 10,  1'b0, 100, 0};
    tbl[1] = '{1, 4,   1'b0, 127, 1};
    tbl[2] = '{1, 8,   1'b0, 125, 0};
    tbl[3] = '{1, 100, 1'b0, 10,  0};
    tbl[4] = '{0, 10,  1'b1, 0,   0};
    tbl[5] = '{0, 10,  1'b0, 0,   0};
    tbl[6] = '{1, 20,  1'b0, 50,  0};
    tbl[7] = '{1, 6,   1'b0, 127, 1};

    // reset held with activity on the inputs
    reset  = 1'b0;
    enable = 1'b1;
    mode   = 1;
    per    = 4;
    repeat (10) begin
      @(negedge clk_in);
      chk("rst_count", freq_count, 0);
      chk("rst_valid", valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);
    end
    @(posedge clk_in);
    #1;
    enable = 1'b0;
    reset  = 1'b1;

    // table-driven patterns, two windows each from a fresh start
    foreach (tbl[i]) begin
      start_run(tbl[i].mode, tbl[i].per, tbl[i].lvl);
      repeat (2) begin
        wait_valid("tbl");
        chk($sformatf("tbl%0d_count", i), freq_count, tbl[i].exp_cnt);
        chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].exp_ovf);
      end
      stop_run();
    end

    // result holds through idle
    repeat (20) @(negedge clk_in);
    chk("idle_hold_count", freq_count, 127);
    chk("idle_hold_ovf", overflow, 1);
    chk("idle_valid", valid, 0);

    // saturation, then recovery to a slow input without stopping
    start_run(1, 4, 1'b0);
    wait_valid("sat");
    chk("sat_count", freq_count, 127);
    chk("sat_ovf", overflow, 1);
    @(negedge clk_in);
    per = 100;
    ph  = 0;
    wait_valid("sat_mix");
    wait_valid("sat_slow");
    chk("slow_count", freq_count, 10);
    chk("slow_ovf", overflow, 0);
    stop_run();

    // abort mid-window
    start_run(1, 10, 1'b0);
    wait_valid("abort_first");
    chk("abort_first_count", freq_count, 100);
    repeat (500) @(posedge clk_in);
    #1;
    enable = 1'b0;
    mon_en = 1'b0;
    @(negedge clk_in);
    chk("abort_busy_still", busy, 1);
    @(negedge clk_in);
    chk("abort_busy_drop", busy, 0);
    chk("abort_hold_count", freq_count, 100);
    nv = 0;
    repeat (CAD + 100) begin
      @(negedge clk_in);
      if (valid) nv++;
    end
    chk("abort_no_valid", nv, 0);
    chk("abort_hold_count2", freq_count, 100);
    chk("abort_hold_ovf", overflow, 0);

    // asynchronous reset about 400 cycles into a window
    start_run(1, 10, 1'b0);
    wait_valid("arst_first");
    chk("arst_first_count", freq_count, 100);
    repeat (400) @(posedge clk_in);
    @(negedge clk_in);
    mode = 0;
    lvl  = 1'b0;
    @(posedge clk_in);
    #1;
    reset  = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("arst_count", freq_count, 0);
    chk("arst_valid", valid, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_busy", busy, 0);
    repeat (2) begin
      @(negedge clk_in);
      chk("arst_hold_valid", valid, 0);
      chk("arst_hold_busy", busy, 0);
    end
    @(negedge clk_in);
    mode = 1;
    per  = 10;
    ph   = 0;
    @(posedge clk_in);
    #1;
    reset  = 1'b1;
    e      = v.size();
    mon_en = 1'b1;
    wait_valid("arst_after");
    chk("arst_after_count", freq_count, 100);
    chk("arst_after_ovf", overflow, 0);
    stop_run();

    // random run lengths against the reference model
    rmax = 9;
    start_run(2, 10, 1'b0);
    repeat (3) wait_valid("rand_slow");
    @(negedge clk_in);
    rmax = 3;
    repeat (3) wait_valid("rand_fast");
    stop_run();

    repeat (5) @(negedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
